// File: rtl/axis_width_packer_pkg.sv
// ----------------------------------------------------------------------------
// axis_width_packer_pkg
// Purpose : shared helpers for the AXI-Stream width packer. They map a beat
//           index to its output lane and build the per-lane keep mask of a
//           word. Lane order is either LSB-first or MSB-first.
// Contents: MAX_LANES - upper bound on lanes per output word
//           lane_index - beat index -> lane position
//           keep_mask  - lanes 0..count set, mirrored when msb_first
// ----------------------------------------------------------------------------
package axis_width_packer_pkg;

    localparam int MAX_LANES = 64;

    // The MSB-first mapping mirrors the lane order. A mirror is its own
    // inverse, so this function also maps a lane back to its beat index.
    function automatic int lane_index(input int count, input int n_lanes, input bit msb_first);
        if (msb_first) begin
            return n_lanes - 1 - count;
        end
        return count;
    endfunction

    // A lane is marked valid when the beat that maps onto it arrived at or
    // before beat 'count'. Lanes beyond n_lanes stay clear, so the caller can
    // truncate the result to its own lane count.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int count, input int n_lanes, input bit msb_first);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int p = 0; p < MAX_LANES; p++) begin
            if (p < n_lanes) begin
                if (lane_index(p, n_lanes, msb_first) <= count) begin
                    mask[p] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_width_packer_if.sv
// ----------------------------------------------------------------------------
// axis_width_packer_if
// Purpose : a minimal AXI-Stream style bundle. The packer uses it twice: once
//           for the narrow pixel input and once for the wide chunk output.
// Signals : tvalid/tready - handshake
//           tdata [DATA_W] - payload
//           tkeep [KEEP_W] - per-lane valid mask (unused on the input side)
//           tlast          - end of packet
// Modports: master drives the payload, slave drives tready.
// ----------------------------------------------------------------------------
interface axis_width_packer_if
    import axis_width_packer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int KEEP_W = 1
);

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);

endinterface

// File: rtl/axis_width_packer.sv
// ----------------------------------------------------------------------------
// axis_width_packer
// Purpose : upsizer. It packs IN_W-bit beats into OUT_W-bit words, with a
//           per-lane keep mask, optional zero padding of partial words and
//           selectable lane order. Under steady drain it takes one beat per
//           cycle with no bubbles.
// Ports   : clk, rst      - clock and synchronous active-high reset
//           pixel (slave) - IN_W-bit input beats; tlast closes a packet
//           chunk (master)- OUT_W-bit words with N_LANES-bit tkeep and tlast
// ----------------------------------------------------------------------------
module axis_width_packer
    import axis_width_packer_pkg::*;
#(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 128,
    parameter bit ZERO_PAD  = 1'b1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    axis_width_packer_if.slave  pixel,
    axis_width_packer_if.master chunk
);

    localparam int N_LANES = OUT_W / IN_W;
    localparam int CNT_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    // Reject widths that cannot be split into at least two whole lanes.
    generate
        if (((OUT_W % IN_W) != 0) || (N_LANES < 2) || (N_LANES > MAX_LANES)) begin : g_bad_widths
            $error("axis_width_packer: OUT_W must be a multiple of IN_W with 2..%0d lanes", MAX_LANES);
        end
    endgenerate

    logic [CNT_W-1:0]   count_q, count_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [N_LANES-1:0] out_keep_q, out_keep_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;

    logic               completes;
    logic               pixel_ready;
    logic               accept;
    int                 lane;
    logic [OUT_W-1:0]   merged;

    // Next-state logic. A beat that completes a word can only enter when the
    // output register is free or is draining on this same edge. That rule
    // makes a separate skid buffer unnecessary. Non-completing beats only
    // touch the accumulator, so they are always accepted. The accumulator is
    // written by lane index and never shifted. With zero padding it is
    // cleared after each word, which leaves the unfilled lanes of the next
    // partial word at zero.
    always_comb begin
        count_d     = count_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        completes   = pixel.tlast || (count_q == CNT_W'(N_LANES - 1));
        pixel_ready = !completes || !out_valid_q || chunk.tready;
        accept      = pixel.tvalid && pixel_ready;
        lane        = lane_index(int'(32'(count_q)), N_LANES, MSB_FIRST);

        merged = acc_q;
        for (int l = 0; l < N_LANES; l++) begin
            if (l == lane) begin
                merged[l*IN_W +: IN_W] = pixel.tdata;
            end
        end

        if (out_valid_q && chunk.tready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (completes) begin
                out_data_d  = merged;
                out_keep_d  = N_LANES'(keep_mask(int'(32'(count_q)), N_LANES, MSB_FIRST));
                out_last_d  = pixel.tlast;
                out_valid_d = 1'b1;
                count_d     = '0;
                acc_d       = ZERO_PAD ? '0 : merged;
            end else begin
                acc_d   = merged;
                count_d = count_q + 1'b1;
            end
        end
    end

    // State register. Reset throws away any partial word and any word held
    // for the downstream side.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pixel.tready = pixel_ready;
    assign chunk.tvalid = out_valid_q;
    assign chunk.tdata  = out_data_q;
    assign chunk.tkeep  = out_keep_q;
    assign chunk.tlast  = out_last_q;

endmodule

// File: tb/tb_axis_width_packer.sv
// ----------------------------------------------------------------------------
// tb_axis_width_packer
// Purpose : directed self-checking bench for axis_width_packer. It builds a
//           default 16->128 LSB-first instance and a 32->64 MSB-first
//           instance that share the clock and reset.
// ----------------------------------------------------------------------------
module tb_axis_width_packer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    axis_width_packer_if #(.DATA_W(16),  .KEEP_W(1)) pix0 ();
    axis_width_packer_if #(.DATA_W(128), .KEEP_W(8)) chk0 ();
    axis_width_packer_if #(.DATA_W(32),  .KEEP_W(1)) pix1 ();
    axis_width_packer_if #(.DATA_W(64),  .KEEP_W(2)) chk1 ();

    axis_width_packer #(
        .IN_W(16), .OUT_W(128), .ZERO_PAD(1'b1), .MSB_FIRST(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .pixel(pix0), .chunk(chk0)
    );

    axis_width_packer #(
        .IN_W(32), .OUT_W(64), .ZERO_PAD(1'b1), .MSB_FIRST(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .pixel(pix1), .chunk(chk1)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Last-resort guard so a wedged run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Offer one beat to the 16-bit instance and return 1 time unit after the
    // edge that accepted it.
    task automatic push0(input logic [15:0] d, input logic last);
        int waited;
        pix0.tvalid = 1'b1;
        pix0.tdata  = d;
        pix0.tlast  = last;
        waited = 0;
        @(negedge clk);
        while (!pix0.tready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!pix0.tready) begin
            checks++;
            errors++;
            $display("[TB] FAIL push0_timeout beat %h never accepted", d);
        end
        @(posedge clk);
        #1;
        pix0.tvalid = 1'b0;
        pix0.tlast  = 1'b0;
    endtask

    // Same as push0, but for the 32-bit MSB-first instance.
    task automatic push1(input logic [31:0] d, input logic last);
        int waited;
        pix1.tvalid = 1'b1;
        pix1.tdata  = d;
        pix1.tlast  = last;
        waited = 0;
        @(negedge clk);
        while (!pix1.tready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!pix1.tready) begin
            checks++;
            errors++;
            $display("[TB] FAIL push1_timeout beat %h never accepted", d);
        end
        @(posedge clk);
        #1;
        pix1.tvalid = 1'b0;
        pix1.tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (chk0.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %b exp 0", chk0.tvalid); end
        checks++; if (chk0.tdata !== 128'h0) begin errors++; $display("[TB] FAIL reset_tdata got %h exp 0", chk0.tdata); end
        checks++; if (chk0.tkeep !== 8'h00) begin errors++; $display("[TB] FAIL reset_tkeep got %h exp 00", chk0.tkeep); end
        checks++; if (chk0.tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %b exp 0", chk0.tlast); end
        checks++; if (chk1.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid1 got %b exp 0", chk1.tvalid); end
        checks++; if (pix0.tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready got %b exp 1", pix0.tready); end
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        chk0.tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push0(16'(i), (i == 8));
            if (i == 7) begin
                checks++; if (chk0.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL full_early_valid got %b exp 0", chk0.tvalid); end
            end
        end
        checks++; if (chk0.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL full_valid got %b exp 1", chk0.tvalid); end
        checks++; if (chk0.tdata !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin errors++; $display("[TB] FAIL full_tdata got %h exp 00080007000600050004000300020001", chk0.tdata); end
        checks++; if (chk0.tkeep !== 8'hFF) begin errors++; $display("[TB] FAIL full_tkeep got %h exp ff", chk0.tkeep); end
        checks++; if (chk0.tlast !== 1'b1) begin errors++; $display("[TB] FAIL full_tlast got %b exp 1", chk0.tlast); end
        @(posedge clk);
        #1;
        checks++; if (chk0.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL full_drain got %b exp 0", chk0.tvalid); end
    endtask

    task automatic test_partial();
        chk0.tready = 1'b1;
        push0(16'h000A, 1'b0);
        push0(16'h000B, 1'b0);
        push0(16'h000C, 1'b1);
        checks++; if (chk0.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL part_valid got %b exp 1", chk0.tvalid); end
        checks++; if (chk0.tdata !== 128'h0000_0000_0000_0000_0000_000C_000B_000A) begin errors++; $display("[TB] FAIL part_tdata got %h exp 000c000b000a", chk0.tdata); end
        checks++; if (chk0.tkeep !== 8'h07) begin errors++; $display("[TB] FAIL part_tkeep got %h exp 07", chk0.tkeep); end
        checks++; if (chk0.tlast !== 1'b1) begin errors++; $display("[TB] FAIL part_tlast got %b exp 1", chk0.tlast); end
        push0(16'h000D, 1'b1);
        checks++; if (chk0.tdata !== 128'h000D) begin errors++; $display("[TB] FAIL single_tdata got %h exp 000d", chk0.tdata); end
        checks++; if (chk0.tkeep !== 8'h01) begin errors++; $display("[TB] FAIL single_tkeep got %h exp 01", chk0.tkeep); end
        checks++; if (chk0.tlast !== 1'b1) begin errors++; $display("[TB] FAIL single_tlast got %b exp 1", chk0.tlast); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [127:0] word1;
        logic [127:0] word2;
        word1 = 128'h0108_0107_0106_0105_0104_0103_0102_0101;
        word2 = 128'h0110_010F_010E_010D_010C_010B_010A_0109;
        chk0.tready = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            push0(16'(16'h0100 + i), 1'b0);
        end
        pix0.tvalid = 1'b1;
        pix0.tdata  = 16'h0110;
        pix0.tlast  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (pix0.tready !== 1'b0) begin errors++; $display("[TB] FAIL stall_tready cyc %0d got %b exp 0", c, pix0.tready); end
            checks++; if (chk0.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid cyc %0d got %b exp 1", c, chk0.tvalid); end
            checks++; if (chk0.tdata !== word1) begin errors++; $display("[TB] FAIL stall_hold_tdata cyc %0d got %h exp %h", c, chk0.tdata, word1); end
        end
        checks++; if (chk0.tkeep !== 8'hFF) begin errors++; $display("[TB] FAIL stall_tkeep got %h exp ff", chk0.tkeep); end
        checks++; if (chk0.tlast !== 1'b0) begin errors++; $display("[TB] FAIL stall_tlast got %b exp 0", chk0.tlast); end
        @(posedge clk);
        #1;
        chk0.tready = 1'b1;
        @(negedge clk);
        checks++; if (pix0.tready !== 1'b1) begin errors++; $display("[TB] FAIL release_tready got %b exp 1", pix0.tready); end
        @(posedge clk);
        #1;
        pix0.tvalid = 1'b0;
        checks++; if (chk0.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL second_valid got %b exp 1", chk0.tvalid); end
        checks++; if (chk0.tdata !== word2) begin errors++; $display("[TB] FAIL second_tdata got %h exp %h", chk0.tdata, word2); end
        checks++; if (chk0.tkeep !== 8'hFF) begin errors++; $display("[TB] FAIL second_tkeep got %h exp ff", chk0.tkeep); end
        @(posedge clk);
        #1;
        checks++; if (chk0.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL stall_final_drain got %b exp 0", chk0.tvalid); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_word;
        chk0.tready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pix0.tvalid = 1'b1;
            pix0.tdata  = 16'(16'h1000 + i);
            pix0.tlast  = 1'b0;
            @(negedge clk);
            checks++; if (pix0.tready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tready beat %0d got %b exp 1", i, pix0.tready); end
            @(posedge clk);
            #1;
            if ((i % 8) == 7) begin
                for (int l = 0; l < 8; l++) begin
                    exp_word[l*16 +: 16] = 16'(16'h1000 + i - 7 + l);
                end
                checks++; if (chk0.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid beat %0d got %b exp 1", i, chk0.tvalid); end
                checks++; if (chk0.tdata !== exp_word) begin errors++; $display("[TB] FAIL b2b_tdata beat %0d got %h exp %h", i, chk0.tdata, exp_word); end
            end else begin
                checks++; if (chk0.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap beat %0d got %b exp 0", i, chk0.tvalid); end
            end
        end
        pix0.tvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        chk0.tready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push0(16'(16'h2000 + i), 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (chk0.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b exp 0", chk0.tvalid); end
        checks++; if (chk0.tdata !== 128'h0) begin errors++; $display("[TB] FAIL midrst_tdata got %h exp 0", chk0.tdata); end
        push0(16'h3001, 1'b0);
        push0(16'h3002, 1'b1);
        checks++; if (chk0.tdata !== 128'h3002_3001) begin errors++; $display("[TB] FAIL midrst_partial got %h exp 30023001", chk0.tdata); end
        checks++; if (chk0.tkeep !== 8'h03) begin errors++; $display("[TB] FAIL midrst_tkeep got %h exp 03", chk0.tkeep); end
        for (int i = 1; i <= 8; i++) begin
            push0(16'(16'h3100 + i), 1'b0);
        end
        checks++; if (chk0.tdata !== 128'h3108_3107_3106_3105_3104_3103_3102_3101) begin errors++; $display("[TB] FAIL midrst_clean got %h exp 31083107310631053104310331023101", chk0.tdata); end
        checks++; if (chk0.tkeep !== 8'hFF) begin errors++; $display("[TB] FAIL midrst_clean_tkeep got %h exp ff", chk0.tkeep); end
        checks++; if (chk0.tlast !== 1'b0) begin errors++; $display("[TB] FAIL midrst_clean_tlast got %b exp 0", chk0.tlast); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_msb_first();
        chk1.tready = 1'b1;
        push1(32'h1111_1111, 1'b0);
        push1(32'h2222_2222, 1'b1);
        checks++; if (chk1.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL msb_valid got %b exp 1", chk1.tvalid); end
        checks++; if (chk1.tdata !== 64'h1111_1111_2222_2222) begin errors++; $display("[TB] FAIL msb_tdata got %h exp 1111111122222222", chk1.tdata); end
        checks++; if (chk1.tkeep !== 2'b11) begin errors++; $display("[TB] FAIL msb_tkeep got %b exp 11", chk1.tkeep); end
        checks++; if (chk1.tlast !== 1'b1) begin errors++; $display("[TB] FAIL msb_tlast got %b exp 1", chk1.tlast); end
        push1(32'h3333_3333, 1'b1);
        checks++; if (chk1.tdata !== 64'h3333_3333_0000_0000) begin errors++; $display("[TB] FAIL msb_single_tdata got %h exp 3333333300000000", chk1.tdata); end
        checks++; if (chk1.tkeep !== 2'b10) begin errors++; $display("[TB] FAIL msb_single_tkeep got %b exp 10", chk1.tkeep); end
        @(posedge clk);
        #1;
        checks++; if (chk1.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL msb_drain got %b exp 0", chk1.tvalid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        pix0.tvalid = 1'b0;
        pix0.tdata  = '0;
        pix0.tkeep  = 1'b1;
        pix0.tlast  = 1'b0;
        chk0.tready = 1'b1;
        pix1.tvalid = 1'b0;
        pix1.tdata  = '0;
        pix1.tkeep  = 1'b1;
        pix1.tlast  = 1'b0;
        chk1.tready = 1'b1;

        test_reset();
        test_full_word();
        test_partial();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_msb_first();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
